// File: rtl/narrow_bus_adapter.sv
// Serialises 32-bit core loads/stores into narrow valid/ready bus beats and
// returns sign- or zero-extended load data with a per-beat timeout.
module narrow_bus_adapter #(
   parameter int unsigned BUS_ADDRESS_WIDTH = 8,
   parameter int unsigned BUS_DATA_WIDTH    = 8,
   parameter int unsigned TIMEOUT_CYCLES    = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cpu_request,
   input  logic                          cpu_write,
   input  logic [2:0]                    cpu_funct3,
   input  logic [31:0]                   cpu_address,
   input  logic [31:0]                   cpu_write_data,
   output logic                          cpu_ready,
   output logic                          cpu_error,
   output logic [31:0]                   cpu_read_data,
   output logic                          bus_valid,
   input  logic                          bus_ready,
   output logic                          bus_write_enable,
   output logic [BUS_ADDRESS_WIDTH-1:0]  bus_address,
   output logic [BUS_DATA_WIDTH/8-1:0]   bus_byte_enable,
   output logic [BUS_DATA_WIDTH-1:0]     bus_write_data,
   input  logic [BUS_DATA_WIDTH-1:0]     bus_read_data
);

   localparam int unsigned BEAT_BYTES = BUS_DATA_WIDTH / 8;
   localparam int unsigned TIMER_W    = $clog2(TIMEOUT_CYCLES + 1) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_BEAT, ST_DONE} state_t;

   state_t               r_state;
   logic                 r_write;
   logic [2:0]           r_funct3;
   logic [31:0]          r_address;
   logic [31:0]          r_wdata;
   logic [2:0]           r_size;
   logic [2:0]           r_nbeats;
   logic [2:0]           r_beat;
   logic [TIMER_W-1:0]   r_timer;
   logic [31:0]          r_rdata;

   logic [2:0]           w_req_size;
   logic                 w_req_err;
   logic [31:0]          w_req_wdata;
   logic [1:0]           w_lane;
   logic                 w_handshake;
   logic                 w_last;
   logic                 w_timeout;
   logic [31:0]          w_rdata_next;

   function automatic logic [2:0] f_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic f_illegal(input logic [2:0] funct3);
      case (funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b0;
         default:                                return 1'b1;
      endcase
   endfunction

   function automatic logic f_misaligned(input logic [2:0] size, input logic [31:0] addr);
      return ((size == 3'd2) && addr[0]) || ((size == 3'd4) && (addr[1:0] != 2'b00));
   endfunction

   function automatic logic [2:0] f_nbeats(input logic [2:0] size);
      if (32'(size) <= BEAT_BYTES) return 3'd1;
      return 3'(32'(size) / BEAT_BYTES);
   endfunction

   function automatic logic [1:0] f_lane(input logic [31:0] addr);
      return 2'(addr & 32'(BEAT_BYTES - 1));
   endfunction

   // Beat base address; wraps modulo the external address space
   function automatic logic [BUS_ADDRESS_WIDTH-1:0] f_beat_addr(input logic [31:0] addr,
                                                                  input logic [2:0]  beat);
      logic [31:0] v_base;
      v_base = (addr & ~32'(BEAT_BYTES - 1)) + 32'(beat) * 32'(BEAT_BYTES);
      return BUS_ADDRESS_WIDTH'(v_base);
   endfunction

   function automatic logic [BEAT_BYTES-1:0] f_byte_en(input logic [2:0]  size,
                                                       input logic [31:0] addr);
      logic [7:0] v_mask;
      if (32'(size) < BEAT_BYTES) begin
         v_mask = (8'd1 << size) - 8'd1;
         v_mask = v_mask << f_lane(addr);
      end else begin
         v_mask = 8'hFF;
      end
      return BEAT_BYTES'(v_mask);
   endfunction

   function automatic logic [BUS_DATA_WIDTH-1:0] f_wdata(input logic [31:0] data,
                                                         input logic [2:0]  size,
                                                         input logic [31:0] addr,
                                                         input logic [2:0]  beat);
      logic [31:0] v_w;
      if (32'(size) < BEAT_BYTES) v_w = data << (8 * f_lane(addr));
      else                        v_w = data >> (BUS_DATA_WIDTH * beat);
      return BUS_DATA_WIDTH'(v_w);
   endfunction

   function automatic logic [31:0] f_extend(input logic [2:0] funct3, input logic [31:0] d);
      case (funct3)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'd0, d[7:0]};
         3'b101:  return {16'd0, d[15:0]};
         default: return d;
      endcase
   endfunction

   // Request decode; store data is masked to the access size up front
   assign w_req_size  = f_size(cpu_funct3);
   assign w_req_err   = f_illegal(cpu_funct3) || f_misaligned(w_req_size, cpu_address);
   assign w_req_wdata = (w_req_size == 3'd1) ? 32'(cpu_write_data[7:0])  :
                        (w_req_size == 3'd2) ? 32'(cpu_write_data[15:0]) : cpu_write_data;

   assign w_lane      = f_lane(r_address);
   assign w_handshake = bus_valid & bus_ready;
   assign w_last      = (r_beat == (r_nbeats - 3'd1));
   assign w_timeout   = (TIMEOUT_CYCLES != 0) && !bus_ready &&
                        (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

   // Little-endian assembly of the beat currently on the bus
   always_comb begin
      w_rdata_next = r_rdata;
      if (32'(r_size) < BEAT_BYTES)
         w_rdata_next = 32'(bus_read_data >> (8 * w_lane));
      else
         w_rdata_next = r_rdata | (32'(bus_read_data) << (BUS_DATA_WIDTH * r_beat));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_write          <= 1'b0;
         r_funct3         <= 3'd0;
         r_address        <= 32'd0;
         r_wdata          <= 32'd0;
         r_size           <= 3'd0;
         r_nbeats         <= 3'd0;
         r_beat           <= 3'd0;
         r_timer          <= '0;
         r_rdata          <= 32'd0;
         cpu_ready        <= 1'b0;
         cpu_error        <= 1'b0;
         cpu_read_data    <= 32'd0;
         bus_valid        <= 1'b0;
         bus_write_enable <= 1'b0;
         bus_address      <= '0;
         bus_byte_enable  <= '0;
         bus_write_data   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               cpu_ready <= 1'b0;
               cpu_error <= 1'b0;
               if (cpu_request) begin
                  r_write   <= cpu_write;
                  r_funct3  <= cpu_funct3;
                  r_address <= cpu_address;
                  r_wdata   <= w_req_wdata;
                  r_size    <= w_req_size;
                  r_nbeats  <= f_nbeats(w_req_size);
                  r_beat    <= 3'd0;
                  r_timer   <= '0;
                  r_rdata   <= 32'd0;
                  if (w_req_err) begin
                     r_state       <= ST_DONE;
                     cpu_ready     <= 1'b1;
                     cpu_error     <= 1'b1;
                     cpu_read_data <= 32'd0;
                  end else begin
                     r_state          <= ST_BEAT;
                     bus_valid        <= 1'b1;
                     bus_write_enable <= cpu_write;
                     bus_address      <= f_beat_addr(cpu_address, 3'd0);
                     bus_byte_enable  <= f_byte_en(w_req_size, cpu_address);
                     bus_write_data   <= f_wdata(w_req_wdata, w_req_size, cpu_address, 3'd0);
                  end
               end
            end
            ST_BEAT: begin
               if (w_handshake) begin
                  r_timer <= '0;
                  r_rdata <= w_rdata_next;
                  if (w_last) begin
                     r_state          <= ST_DONE;
                     bus_valid        <= 1'b0;
                     bus_write_enable <= 1'b0;
                     cpu_ready        <= 1'b1;
                     cpu_error        <= 1'b0;
                     cpu_read_data    <= r_write ? 32'd0 : f_extend(r_funct3, w_rdata_next);
                  end else begin
                     r_beat         <= r_beat + 3'd1;
                     bus_address    <= f_beat_addr(r_address, r_beat + 3'd1);
                     bus_write_data <= f_wdata(r_wdata, r_size, r_address, r_beat + 3'd1);
                  end
               end else if (w_timeout) begin
                  r_state          <= ST_DONE;
                  r_timer          <= '0;
                  bus_valid        <= 1'b0;
                  bus_write_enable <= 1'b0;
                  cpu_ready        <= 1'b1;
                  cpu_error        <= 1'b1;
                  cpu_read_data    <= 32'd0;
               end else begin
                  r_timer <= r_timer + TIMER_W'(1);
               end
            end
            ST_DONE: begin
               r_state       <= ST_IDLE;
               cpu_ready     <= 1'b0;
               cpu_error     <= 1'b0;
               cpu_read_data <= 32'd0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_narrow_bus_adapter.sv
// Directed bench: an 8-bit bus instance (timeout 4) and a 16-bit bus instance.
module tb_narrow_bus_adapter;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // Instance A: 8-bit bus, 4-cycle timeout
   logic        a_cpu_request, a_cpu_write, a_cpu_ready, a_cpu_error;
   logic [2:0]  a_cpu_funct3;
   logic [31:0] a_cpu_address, a_cpu_write_data, a_cpu_read_data;
   logic        a_bus_valid, a_bus_ready, a_bus_write_enable;
   logic [7:0]  a_bus_address;
   logic [0:0]  a_bus_byte_enable;
   logic [7:0]  a_bus_write_data, a_bus_read_data;
   logic [7:0]  a_mem [256];

   // Instance B: 16-bit bus
   logic        b_cpu_request, b_cpu_write, b_cpu_ready, b_cpu_error;
   logic [2:0]  b_cpu_funct3;
   logic [31:0] b_cpu_address, b_cpu_write_data, b_cpu_read_data;
   logic        b_bus_valid, b_bus_ready, b_bus_write_enable;
   logic [7:0]  b_bus_address;
   logic [1:0]  b_bus_byte_enable;
   logic [15:0] b_bus_write_data, b_bus_read_data;

   int n_tests = 0;
   int n_fail  = 0;

   assign a_bus_read_data = a_mem[a_bus_address];

   narrow_bus_adapter #(.BUS_ADDRESS_WIDTH(8), .BUS_DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) u_dut_a (
      .clock(clock), .reset(reset),
      .cpu_request(a_cpu_request), .cpu_write(a_cpu_write), .cpu_funct3(a_cpu_funct3),
      .cpu_address(a_cpu_address), .cpu_write_data(a_cpu_write_data),
      .cpu_ready(a_cpu_ready), .cpu_error(a_cpu_error), .cpu_read_data(a_cpu_read_data),
      .bus_valid(a_bus_valid), .bus_ready(a_bus_ready), .bus_write_enable(a_bus_write_enable),
      .bus_address(a_bus_address), .bus_byte_enable(a_bus_byte_enable),
      .bus_write_data(a_bus_write_data), .bus_read_data(a_bus_read_data)
   );

   narrow_bus_adapter #(.BUS_ADDRESS_WIDTH(8), .BUS_DATA_WIDTH(16), .TIMEOUT_CYCLES(16)) u_dut_b (
      .clock(clock), .reset(reset),
      .cpu_request(b_cpu_request), .cpu_write(b_cpu_write), .cpu_funct3(b_cpu_funct3),
      .cpu_address(b_cpu_address), .cpu_write_data(b_cpu_write_data),
      .cpu_ready(b_cpu_ready), .cpu_error(b_cpu_error), .cpu_read_data(b_cpu_read_data),
      .bus_valid(b_bus_valid), .bus_ready(b_bus_ready), .bus_write_enable(b_bus_write_enable),
      .bus_address(b_bus_address), .bus_byte_enable(b_bus_byte_enable),
      .bus_write_data(b_bus_write_data), .bus_read_data(b_bus_read_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic a_issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      a_cpu_request = 1'b1; a_cpu_write = wr; a_cpu_funct3 = f3;
      a_cpu_address = addr; a_cpu_write_data = wd;
      tick();
      a_cpu_request = 1'b0;
   endtask

   task automatic b_issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      b_cpu_request = 1'b1; b_cpu_write = wr; b_cpu_funct3 = f3;
      b_cpu_address = addr; b_cpu_write_data = wd;
      tick();
      b_cpu_request = 1'b0;
   endtask

   task automatic a_chk_beat(input string tag, input logic [7:0] addr, input logic [7:0] wd,
                             input logic we);
      check({tag, "_valid"}, 32'(a_bus_valid), 32'd1);
      check({tag, "_addr"},  32'(a_bus_address), 32'(addr));
      check({tag, "_we"},    32'(a_bus_write_enable), 32'(we));
      check({tag, "_ready"}, 32'(a_cpu_ready), 32'd0);
      if (we) check({tag, "_wdata"}, 32'(a_bus_write_data), 32'(wd));
   endtask

   task automatic a_chk_done(input string tag, input logic err, input logic [31:0] rd);
      check({tag, "_ready"}, 32'(a_cpu_ready), 32'd1);
      check({tag, "_error"}, 32'(a_cpu_error), 32'(err));
      check({tag, "_rdata"}, a_cpu_read_data, rd);
      check({tag, "_valid"}, 32'(a_bus_valid), 32'd0);
      tick();
      check({tag, "_pulse"}, 32'(a_cpu_ready), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      a_cpu_request = 0; a_cpu_write = 0; a_cpu_funct3 = 0; a_cpu_address = 0;
      a_cpu_write_data = 0; a_bus_ready = 0;
      b_cpu_request = 0; b_cpu_write = 0; b_cpu_funct3 = 0; b_cpu_address = 0;
      b_cpu_write_data = 0; b_bus_ready = 0; b_bus_read_data = 0;
      for (int i = 0; i < 256; i++) a_mem[i] = 8'h00;
      a_mem[4] = 8'h11; a_mem[5] = 8'h22; a_mem[6] = 8'h33; a_mem[7] = 8'h44;
      a_mem[8'h20] = 8'h9C;
      tick(); tick(); tick();

      check("rst_ready", 32'(a_cpu_ready), 32'd0);
      check("rst_error", 32'(a_cpu_error), 32'd0);
      check("rst_valid", 32'(a_bus_valid), 32'd0);
      check("rst_we",    32'(a_bus_write_enable), 32'd0);
      check("rst_addr",  32'(a_bus_address), 32'd0);
      check("rst_be",    32'(b_bus_byte_enable), 32'd0);
      check("rst_wdata", 32'(b_bus_write_data), 32'd0);
      check("rst_rdata", a_cpu_read_data, 32'd0);
      reset = 1'b0;
      tick();

      // lw at 0x04 over four back-to-back beats
      a_bus_ready = 1'b1;
      a_issue(1'b0, 3'b010, 32'h04, 32'h0);
      for (int k = 0; k < 4; k++) begin
         a_chk_beat($sformatf("t1_b%0d", k), 8'(8'h04 + k), 8'h00, 1'b0);
         tick();
      end
      a_chk_done("t1_done", 1'b0, 32'h44332211);

      // sh 0xBEEF at 0x0A with two wait states per beat
      a_bus_ready = 1'b0;
      a_issue(1'b1, 3'b001, 32'h0A, 32'h1234BEEF);
      for (int k = 0; k < 2; k++) begin
         a_chk_beat($sformatf("t2_b%0d_s0", k), 8'(8'h0A + k), (k == 0) ? 8'hEF : 8'hBE, 1'b1);
         tick();
         a_chk_beat($sformatf("t2_b%0d_s1", k), 8'(8'h0A + k), (k == 0) ? 8'hEF : 8'hBE, 1'b1);
         tick();
         a_chk_beat($sformatf("t2_b%0d_s2", k), 8'(8'h0A + k), (k == 0) ? 8'hEF : 8'hBE, 1'b1);
         a_bus_ready = 1'b1;
         tick();
         a_bus_ready = 1'b0;
      end
      a_chk_done("t2_done", 1'b0, 32'h0);

      // Misaligned lw and illegal funct3: immediate error, no bus beat
      a_issue(1'b0, 3'b010, 32'h02, 32'h0);
      a_chk_done("t4_misal", 1'b1, 32'h0);
      a_issue(1'b0, 3'b011, 32'h00, 32'h0);
      a_chk_done("t4_illegal", 1'b1, 32'h0);
      a_issue(1'b1, 3'b001, 32'h03, 32'hFFFF);
      a_chk_done("t4_misal_sh", 1'b1, 32'h0);

      // Timeout after four stalled cycles, then a normal lbu/lb
      a_bus_ready = 1'b0;
      a_issue(1'b0, 3'b010, 32'h10, 32'h0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t5_stall%0d_valid", k), 32'(a_bus_valid), 32'd1);
         tick();
      end
      a_chk_done("t5_timeout", 1'b1, 32'h0);
      a_bus_ready = 1'b1;
      a_issue(1'b0, 3'b100, 32'h20, 32'h0);
      a_chk_beat("t5_lbu", 8'h20, 8'h00, 1'b0);
      tick();
      a_chk_done("t5_lbu_done", 1'b0, 32'h0000009C);
      a_issue(1'b0, 3'b000, 32'h20, 32'h0);
      tick();
      a_chk_done("t5_lb_done", 1'b0, 32'hFFFFFF9C);

      // sw at 0xFC: beats 0xFC..0xFF
      a_issue(1'b1, 3'b010, 32'hFC, 32'hDEADBEEF);
      for (int k = 0; k < 4; k++) begin
         a_chk_beat($sformatf("t6_b%0d", k), 8'(8'hFC + k),
                    (k == 0) ? 8'hEF : (k == 1) ? 8'hBE : (k == 2) ? 8'hAD : 8'hDE, 1'b1);
         tick();
      end
      a_chk_done("t6_done", 1'b0, 32'h0);

      // sw at 0x1FC truncates to 0xFC; reset during the second beat aborts it
      a_issue(1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D);
      a_chk_beat("t6r_b0", 8'hFC, 8'h0D, 1'b1);
      tick();
      a_chk_beat("t6r_b1", 8'hFD, 8'hF0, 1'b1);
      reset = 1'b1;
      tick();
      check("t6r_rst_valid", 32'(a_bus_valid), 32'd0);
      check("t6r_rst_ready", 32'(a_cpu_ready), 32'd0);
      check("t6r_rst_addr",  32'(a_bus_address), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("t6r_post%0d_ready", k), 32'(a_cpu_ready), 32'd0);
         check($sformatf("t6r_post%0d_valid", k), 32'(a_bus_valid), 32'd0);
      end

      // 16-bit bus: sub-beat lanes, byte enables and multi-beat word
      b_bus_ready = 1'b1;
      b_bus_read_data = 16'h80AA;
      b_issue(1'b0, 3'b000, 32'h03, 32'h0);
      check("t3_lb_addr", 32'(b_bus_address), 32'h02);
      check("t3_lb_be",   32'(b_bus_byte_enable), 32'b10);
      tick();
      check("t3_lb_ready", 32'(b_cpu_ready), 32'd1);
      check("t3_lb_rdata", b_cpu_read_data, 32'hFFFFFF80);
      tick();
      b_issue(1'b0, 3'b100, 32'h03, 32'h0);
      tick();
      check("t3_lbu_rdata", b_cpu_read_data, 32'h00000080);
      tick();

      b_issue(1'b0, 3'b010, 32'h04, 32'h0);
      b_bus_read_data = 16'h2211;
      check("t3_lw_addr0", 32'(b_bus_address), 32'h04);
      check("t3_lw_be0",   32'(b_bus_byte_enable), 32'b11);
      tick();
      b_bus_read_data = 16'h4433;
      check("t3_lw_addr1", 32'(b_bus_address), 32'h06);
      tick();
      check("t3_lw_ready", 32'(b_cpu_ready), 32'd1);
      check("t3_lw_rdata", b_cpu_read_data, 32'h44332211);
      tick();

      b_issue(1'b1, 3'b000, 32'h05, 32'h7777775A);
      check("t3_sb_addr",  32'(b_bus_address), 32'h04);
      check("t3_sb_be",    32'(b_bus_byte_enable), 32'b10);
      check("t3_sb_wdata", 32'(b_bus_write_data), 32'h5A00);
      check("t3_sb_we",    32'(b_bus_write_enable), 32'd1);
      tick();
      check("t3_sb_rdata", b_cpu_read_data, 32'h0);
      tick();

      b_issue(1'b1, 3'b001, 32'h06, 32'h0000BEEF);
      check("t3_sh_addr",  32'(b_bus_address), 32'h06);
      check("t3_sh_be",    32'(b_bus_byte_enable), 32'b11);
      check("t3_sh_wdata", 32'(b_bus_write_data), 32'hBEEF);
      tick();
      check("t3_sh_ready", 32'(b_cpu_ready), 32'd1);
      tick();

      b_bus_read_data = 16'h8001;
      b_issue(1'b0, 3'b001, 32'h08, 32'h0);
      tick();
      check("t3_lh_rdata", b_cpu_read_data, 32'hFFFF8001);
      tick();
      b_issue(1'b0, 3'b101, 32'h08, 32'h0);
      tick();
      check("t3_lhu_rdata", b_cpu_read_data, 32'h00008001);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
